// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing and framebuffer constants
// Purpose: 640x480@60 timing defaults, framebuffer geometry and widths shared by
//   the scan-out reader and the rectangle drawer.
// Ports: none (package).
package vga_pkg;

  // Framebuffer geometry and data widths
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 12;
  localparam int CNT_W     = 10;

  // 640x480@60 porch and sync widths (pixels / lines)
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Per-position attributes decoded from the counters; sync levels are active-low
  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic first;
  } pix_attr_t;

  localparam pix_attr_t PIX_ATTR_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, first: 1'b0};

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - pixel-enabled h/v scan counters with sync/active decode
// Purpose: steps the scan position once per pix_tick and decodes the attributes of
//   the position currently held in the counters.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   pix_tick_i     advance one position
//   attr_o         active / hsync_n / vsync_n / first for the current position
//   wrap_o         current position is the last of the frame
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = FB_WIDTH,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = FB_HEIGHT,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pix_tick_i,
  output pix_attr_t attr_o,
  output logic      wrap_o
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_last, v_last;

  assign h_last = (int'(h_cnt_q) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_q) == V_TOTAL - 1);
  assign wrap_o = h_last && v_last;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    attr_o         = PIX_ATTR_IDLE;
    attr_o.active  = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    attr_o.hsync_n = !((int'(h_cnt_q) >= H_SYNC_START) && (int'(h_cnt_q) < H_SYNC_END));
    attr_o.vsync_n = !((int'(v_cnt_q) >= V_SYNC_START) && (int'(v_cnt_q) < V_SYNC_END));
    attr_o.first   = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// rtl/vga_framebuffer_reader.sv - VGA scan-out reader for the RGB444 framebuffer
// Purpose: generates VGA timing, fetches one pixel per active position from the
//   synchronous framebuffer RAM and presents it one pixel period later, aligned
//   with hsync/vsync.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   pix_tick       one-clk pixel-rate enable
//   read_enable    one-clk read strobe to the RAM
//   read_addr      pixel address y*H_ACTIVE+x
//   read_data      RAM data, valid READ_LATENCY clks after read_enable
//   hsync, vsync   active-low syncs
//   active_video   rgb carries a visible pixel
//   rgb            pixel colour, 0 in blanking
//   frame_start    one-clk pulse with presentation of (0,0)
//   underrun       sticky: a visible pixel had no data by its presentation tick
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = FB_WIDTH,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = FB_HEIGHT,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic              hsync,
  output logic              vsync,
  output logic              active_video,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  pix_attr_t fetch_attr;
  logic      wrap;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_tick_i (pix_tick),
    .attr_o     (fetch_attr),
    .wrap_o     (wrap)
  );

  logic [ADDR_W-1:0]       addr_cnt_q, addr_cnt_d;
  logic                    read_enable_q, read_enable_d;
  logic [ADDR_W-1:0]       read_addr_q, read_addr_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic                    captured_q, captured_d;
  pix_attr_t               stage_q, stage_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    active_q, active_d;
  logic [DATA_W-1:0]       rgb_q, rgb_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  logic                    capture_now;
  logic                    pixel_ready;
  logic [DATA_W-1:0]       pixel_data;

  // Data returning in the same clk as the presentation tick is forwarded directly
  assign capture_now = rd_pipe_q[READ_LATENCY-1];
  assign pixel_ready = captured_q || capture_now;
  assign pixel_data  = capture_now ? read_data : hold_q;

  always_comb begin
    addr_cnt_d    = addr_cnt_q;
    read_enable_d = 1'b0;
    read_addr_d   = read_addr_q;
    hold_d        = hold_q;
    captured_d    = captured_q;
    stage_d       = stage_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;

    rd_pipe_d    = '0;
    rd_pipe_d[0] = read_enable_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    if (capture_now) begin
      hold_d     = read_data;
      captured_d = 1'b1;
    end

    if (pix_tick) begin
      // Fetch for the position now in the counters
      if (fetch_attr.active) begin
        read_enable_d = 1'b1;
        read_addr_d   = addr_cnt_q;
        addr_cnt_d    = (addr_cnt_q == LAST_ADDR) ? '0 : addr_cnt_q + ADDR_W'(1);
      end
      if (wrap) begin
        addr_cnt_d = '0;
      end

      // Present the position fetched on the previous tick
      hsync_d       = stage_q.hsync_n;
      vsync_d       = stage_q.vsync_n;
      active_d      = stage_q.active;
      frame_start_d = stage_q.first;
      rgb_d         = '0;
      if (stage_q.active) begin
        if (pixel_ready) begin
          rgb_d = pixel_data;
        end else begin
          underrun_d = 1'b1;
        end
      end

      // Anything still in flight belongs to the pixel just presented; a late
      // return must not be mistaken for the next pixel's data.
      captured_d = 1'b0;
      rd_pipe_d  = '0;
      stage_d    = fetch_attr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt_q    <= '0;
      read_enable_q <= 1'b0;
      read_addr_q   <= '0;
      rd_pipe_q     <= '0;
      hold_q        <= '0;
      captured_q    <= 1'b0;
      stage_q       <= PIX_ATTR_IDLE;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      addr_cnt_q    <= addr_cnt_d;
      read_enable_q <= read_enable_d;
      read_addr_q   <= read_addr_d;
      rd_pipe_q     <= rd_pipe_d;
      hold_q        <= hold_d;
      captured_q    <= captured_d;
      stage_q       <= stage_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign read_enable  = read_enable_q;
  assign read_addr    = read_addr_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign active_video = active_q;
  assign rgb          = rgb_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// tb/tb_vga_framebuffer_reader.sv - scoreboard bench for vga_framebuffer_reader
module tb_vga_framebuffer_reader;
  import vga_pkg::*;

  localparam int NI = 2;   // 0: full 640x480 timing, 1: reduced geometry for whole frames
  localparam int RL = 2;

  int ha  [NI] = '{640, 16};
  int hfp [NI] = '{16, 2};
  int hsw [NI] = '{96, 4};
  int hbp [NI] = '{48, 2};
  int va  [NI] = '{480, 8};
  int vfp [NI] = '{10, 2};
  int vsw [NI] = '{2, 2};
  int vbp [NI] = '{33, 2};

  logic clk = 1'b0;
  logic reset;
  logic pix_tick;

  wire  [NI-1:0]             re, hs_o, vs_o, av, fs, ur;
  wire  [NI-1:0][ADDR_W-1:0] ra;
  wire  [NI-1:0][DATA_W-1:0] rgb;
  logic [NI-1:0][DATA_W-1:0] rd;

  always #5 clk = ~clk;

  vga_framebuffer_reader #(.READ_LATENCY(RL)) u_full (
    .clk(clk), .reset(reset), .pix_tick(pix_tick),
    .read_enable(re[0]), .read_addr(ra[0]), .read_data(rd[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .active_video(av[0]), .rgb(rgb[0]),
    .frame_start(fs[0]), .underrun(ur[0])
  );

  vga_framebuffer_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .READ_LATENCY(RL)
  ) u_small (
    .clk(clk), .reset(reset), .pix_tick(pix_tick),
    .read_enable(re[1]), .read_addr(ra[1]), .read_data(rd[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .active_video(av[1]), .rgb(rgb[1]),
    .frame_start(fs[1]), .underrun(ur[1])
  );

  // RAM model, latency 2, content = addr[11:0]; invalid slots read as 12'hBAD.
  // It ignores reset so in-flight reads still return after a reset.
  logic [NI-1:0]             r1_en;
  logic [NI-1:0][ADDR_W-1:0] r1_a;
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      r1_en[i] <= re[i];
      r1_a[i]  <= ra[i];
      rd[i]    <= r1_en[i] ? r1_a[i][DATA_W-1:0] : 12'hBAD;
    end
  end

  typedef struct {
    logic              act;
    logic              hs;
    logic              vs;
    logic [DATA_W-1:0] rgb;
    logic              fs;
    int                fetch_cyc;
  } exp_t;

  typedef struct {
    int div;
    int ticks;
    int fs_full;
    int fs_small;
    int hs_low_full;
    int ur_full;
    int ur_small;
  } row_t;

  exp_t              sbq0[$];
  exp_t              sbq1[$];
  exp_t              cur    [NI];
  int                mh     [NI];
  int                mv     [NI];
  logic [ADDR_W-1:0] last_ra[NI];
  logic              mur    [NI];
  int                fs_cnt [NI];
  int                hs_low_full;
  int                cyc;
  int                n_vec;
  int                n_bad;
  row_t              rows[4];

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, i, cyc, got, want);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0; e.fs = 1'b0; e.fetch_cyc = -1000;
    return e;
  endfunction

  function automatic void sb_push(int i, exp_t e);
    if (i == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endfunction

  task automatic sb_pop(input int i, output exp_t e);
    e = idle_rec();
    if (i == 0 && sbq0.size() > 0)      e = sbq0.pop_front();
    else if (i == 1 && sbq1.size() > 0) e = sbq1.pop_front();
    else chk("scoreboard_empty", i, 1, 0);
  endtask

  function automatic void model_reset();
    sbq0.delete();
    sbq1.delete();
    for (int i = 0; i < NI; i++) begin
      mh[i] = 0; mv[i] = 0; last_ra[i] = '0; mur[i] = 1'b0;
      cur[i] = idle_rec();
      sb_push(i, idle_rec());
    end
  endfunction

  task automatic check_cycle(input bit tick);
    for (int i = 0; i < NI; i++) begin
      if (tick) begin
        bit   a;
        int   addr;
        exp_t e;
        exp_t n;
        int   ht;
        int   vt;
        a    = (mh[i] < ha[i]) && (mv[i] < va[i]);
        addr = mv[i] * ha[i] + mh[i];
        chk("read_enable", i, re[i], a);
        if (a) last_ra[i] = ADDR_W'(addr);

        sb_pop(i, e);
        if (e.act && (cyc - e.fetch_cyc) < RL + 1) begin
          mur[i] = 1'b1;
          e.rgb  = '0;
        end
        cur[i] = e;

        n.act = a;
        n.hs  = !(mh[i] >= ha[i] + hfp[i] && mh[i] < ha[i] + hfp[i] + hsw[i]);
        n.vs  = !(mv[i] >= va[i] + vfp[i] && mv[i] < va[i] + vfp[i] + vsw[i]);
        n.rgb = a ? DATA_W'(addr) : '0;
        n.fs  = (mh[i] == 0) && (mv[i] == 0);
        n.fetch_cyc = cyc;
        sb_push(i, n);

        ht = ha[i] + hfp[i] + hsw[i] + hbp[i];
        vt = va[i] + vfp[i] + vsw[i] + vbp[i];
        mh[i]++;
        if (mh[i] == ht) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == vt) mv[i] = 0;
        end

        if (fs[i]) fs_cnt[i]++;
        if (i == 0 && !hs_o[0]) hs_low_full++;
      end else begin
        chk("read_enable_idle", i, re[i], 0);
      end
      chk("read_addr", i, ra[i], last_ra[i]);
      chk("hsync", i, hs_o[i], cur[i].hs);
      chk("vsync", i, vs_o[i], cur[i].vs);
      chk("active_video", i, av[i], cur[i].act);
      chk("rgb", i, rgb[i], cur[i].rgb);
      chk("frame_start", i, fs[i], tick ? cur[i].fs : 1'b0);
      chk("underrun", i, ur[i], mur[i]);
    end
  endtask

  task automatic clock_cycle(input bit tick);
    pix_tick = tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle(tick);
  endtask

  task automatic run_ticks(input int div, input int n);
    for (int k = 0; k < n; k++) begin
      clock_cycle(1'b1);
      for (int j = 1; j < div; j++) clock_cycle(1'b0);
    end
  endtask

  // Called at a negedge; reset takes effect at once, outputs checked before any edge
  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    pix_tick = 1'b0;
    #1;
    model_reset();
    check_cycle(1'b0);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_cycle(1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < NI; i++) fs_cnt[i] = 0;
    hs_low_full = 0;
  endtask

  initial begin
    reset       = 1'b1;
    pix_tick    = 1'b0;
    cyc         = 0;
    n_vec       = 0;
    n_bad       = 0;
    hs_low_full = 0;

    rows[0] = '{div: 4, ticks: 900, fs_full: 1, fs_small: 3, hs_low_full: 96, ur_full: 0, ur_small: 0};
    rows[1] = '{div: 3, ticks: 400, fs_full: 1, fs_small: 2, hs_low_full: 0,  ur_full: 0, ur_small: 0};
    rows[2] = '{div: 5, ticks: 340, fs_full: 1, fs_small: 2, hs_low_full: 0,  ur_full: 0, ur_small: 0};
    rows[3] = '{div: 2, ticks: 400, fs_full: 1, fs_small: 2, hs_low_full: 0,  ur_full: 1, ur_small: 1};

    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      do_reset(2);
      run_ticks(rows[r].div, rows[r].ticks);
      chk("frame_start_count", 0, fs_cnt[0], rows[r].fs_full);
      chk("frame_start_count", 1, fs_cnt[1], rows[r].fs_small);
      chk("hsync_low_ticks", 0, hs_low_full, rows[r].hs_low_full);
      chk("underrun_final", 0, ur[0], rows[r].ur_full);
      chk("underrun_final", 1, ur[1], rows[r].ur_small);
    end

    // Underrun stays set once the tick spacing is comfortable again
    run_ticks(4, 30);
    chk("underrun_sticky", 0, ur[0], 1);
    chk("underrun_sticky", 1, ur[1], 1);

    // Reset with a read in flight mid-frame; the late RAM return must be ignored
    do_reset(2);
    run_ticks(4, 100);
    clock_cycle(1'b1);
    chk("read_in_flight", 0, re[0], 1);
    chk("read_in_flight", 1, re[1], 1);
    do_reset(1);
    run_ticks(3, 60);
    chk("underrun_after_reset", 0, ur[0], 0);
    chk("underrun_after_reset", 1, ur[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
